// File: rtl/fir_mac_scheduler.sv
// Time-multiplexed scheduler for the 31-tap symmetric FIR: sample ring, one shared MAC, round/saturate.
// Optional build macro FIR_BYPASS_EN adds a bypass input that forwards the raw sample with 2-cycle latency.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for sample_valid; accepts into the ring
// S_MAC   | one coefficient pair per cycle, k = 0 .. NPAIR-1
// S_ROUND | round, saturate and publish filtered (or raw sample on bypass)
module fir_mac_scheduler #(
    parameter int TAPS = 31,
    parameter int DW   = 10,
    parameter int CW   = 16,
    parameter int ACCW = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sample_valid,
    input  logic [DW-1:0]        sample,
    output logic [$clog2((TAPS+1)/2)-1:0] coef_idx,
    input  logic [CW-1:0]        coef,
    output logic                 busy,
    output logic [DW-1:0]        filtered,
    output logic                 filtered_valid,
    output logic                 overrun,
    input  logic                 clear_overrun
`ifdef FIR_BYPASS_EN
    ,
    input  logic                 bypass
`endif
);

    localparam int NPAIR = (TAPS + 1) / 2;
    localparam int KW    = $clog2(NPAIR);
    localparam int PW    = $clog2(TAPS);
    localparam int PRW   = CW + DW + 2;

    localparam logic [PW:0]             TAPS_X = (PW+1)'(TAPS);
    localparam logic [KW-1:0]           K_LAST = KW'(NPAIR - 1);
    localparam logic [PW-1:0]           P_LAST = PW'(TAPS - 1);
    localparam logic signed [ACCW-1:0]  HALF   = ACCW'(1) <<< (CW - 2);
    localparam logic signed [ACCW-1:0]  MAXV   = ACCW'((1 << DW) - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MAC   = 2'd1,
        S_ROUND = 2'd2
    } state_t;

    state_t                 state_q;
    logic [DW-1:0]          ring_q [TAPS];
    logic [PW-1:0]          wr_ptr_q;
    logic [PW-1:0]          newest_q;
    logic [KW-1:0]          k_q;
    logic signed [ACCW-1:0] acc_q;
    logic [DW-1:0]          filtered_q;
    logic                   filtered_valid_q;
    logic                   busy_q;
    logic                   overrun_q;
    logic                   bypass_q;

    logic                   bypass_sel;
    logic                   last_step;
    logic [PW:0]            newest_x;
    logic [PW:0]            k_x;
    logic [PW:0]            lo_x;
    logic [PW:0]            hi_x;
    logic [DW:0]            pair;
    logic signed [PRW-1:0]  prod;
    logic signed [ACCW-1:0] acc_d;
    logic signed [ACCW-1:0] rnd;
    logic signed [ACCW-1:0] shr;
    logic [DW-1:0]          filt_d;

`ifdef FIR_BYPASS_EN
    assign bypass_sel = bypass;
`else
    assign bypass_sel = 1'b0;
`endif

    assign last_step = (k_q == K_LAST);

    // Ring addresses of the two taps sharing coefficient k, reduced mod TAPS.
    always_comb begin
        newest_x = {1'b0, newest_q};
        k_x      = (PW+1)'(k_q);
        lo_x     = '0;
        hi_x     = '0;
        if (newest_x >= k_x) begin
            lo_x = newest_x - k_x;
        end else begin
            lo_x = newest_x + TAPS_X - k_x;
        end
        hi_x = newest_x + k_x + 1'b1;
        if (hi_x >= TAPS_X) begin
            hi_x = hi_x - TAPS_X;
        end
    end

    // The centre tap has no partner, so its pair is the single sample.
    always_comb begin
        pair = {1'b0, ring_q[lo_x[PW-1:0]]};
        if (!last_step) begin
            pair = pair + {1'b0, ring_q[hi_x[PW-1:0]]};
        end
        prod  = PRW'($signed(coef)) * PRW'($signed({1'b0, pair}));
        acc_d = acc_q + ACCW'(prod);
    end

    always_comb begin
        rnd    = acc_q + HALF;
        shr    = rnd >>> (CW - 1);
        filt_d = '0;
        if (shr[ACCW-1]) begin
            filt_d = '0;
        end else if (shr > MAXV) begin
            filt_d = '1;
        end else begin
            filt_d = shr[DW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= S_IDLE;
            for (int i = 0; i < TAPS; i++) begin
                ring_q[i] <= '0;
            end
            wr_ptr_q         <= '0;
            newest_q         <= '0;
            k_q              <= '0;
            acc_q            <= '0;
            filtered_q       <= '0;
            filtered_valid_q <= 1'b0;
            busy_q           <= 1'b0;
            overrun_q        <= 1'b0;
            bypass_q         <= 1'b0;
        end else begin
            filtered_valid_q <= 1'b0;

            // A drop in the same cycle as a clear leaves the flag set.
            if (sample_valid && (state_q != S_IDLE)) begin
                overrun_q <= 1'b1;
            end else if (clear_overrun) begin
                overrun_q <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    if (sample_valid) begin
                        ring_q[wr_ptr_q] <= sample;
                        newest_q         <= wr_ptr_q;
                        wr_ptr_q         <= (wr_ptr_q == P_LAST) ? '0 : wr_ptr_q + 1'b1;
                        acc_q            <= '0;
                        k_q              <= '0;
                        busy_q           <= 1'b1;
                        bypass_q         <= bypass_sel;
                        state_q          <= bypass_sel ? S_ROUND : S_MAC;
                    end
                end
                S_MAC: begin
                    acc_q <= acc_d;
                    if (last_step) begin
                        k_q     <= '0;
                        state_q <= S_ROUND;
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                S_ROUND: begin
                    filtered_q       <= bypass_q ? ring_q[newest_q] : filt_d;
                    filtered_valid_q <= 1'b1;
                    busy_q           <= 1'b0;
                    state_q          <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign coef_idx       = k_q;
    assign busy           = busy_q;
    assign filtered       = filtered_q;
    assign filtered_valid = filtered_valid_q;
    assign overrun        = overrun_q;

endmodule

// File: tb/tb_fir_mac_scheduler.sv
// Directed bench for fir_mac_scheduler: direct-form FIR model feeds a scoreboard of (value, due cycle).
module tb_fir_mac_scheduler;

    logic               clk = 1'b0;
    logic               reset;
    logic               sample_valid;
    logic [9:0]         sample;
    logic [3:0]         coef_idx;
    logic [15:0]        coef;
    logic               busy;
    logic [9:0]         filtered;
    logic               filtered_valid;
    logic               overrun;
    logic               clear_overrun;
`ifdef FIR_BYPASS_EN
    logic               bypass;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int ctab [16];
    int hist [31];

    typedef struct {
        int val;
        int due;
    } exp_t;

    exp_t sb [$];
    int   got [$];

    fir_mac_scheduler dut (
        .clk            (clk),
        .reset          (reset),
        .sample_valid   (sample_valid),
        .sample         (sample),
        .coef_idx       (coef_idx),
        .coef           (coef),
        .busy           (busy),
        .filtered       (filtered),
        .filtered_valid (filtered_valid),
        .overrun        (overrun),
        .clear_overrun  (clear_overrun)
`ifdef FIR_BYPASS_EN
        ,
        .bypass         (bypass)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign coef = 16'(ctab[coef_idx]);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    // Direct-form reference: tap j uses coefficient min(j, 30-j) on the j-th newest sample.
    function automatic int model_push(input int x);
        longint acc;
        acc = 0;
        for (int j = 30; j > 0; j--) hist[j] = hist[j-1];
        hist[0] = x;
        for (int j = 0; j < 31; j++) begin
            acc += longint'(ctab[(j <= 15) ? j : 30 - j]) * longint'(hist[j]);
        end
        acc = (acc + 64'sd16384) >>> 15;
        if (acc < 0) return 0;
        if (acc > 1023) return 1023;
        return int'(acc);
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (filtered_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid", {31'd0, filtered_valid}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("filtered", {22'd0, filtered}, e.val);
                chk("latency", cyc, e.due);
                got.push_back(int'(filtered));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input int x, input bit push);
        exp_t e;
        if (push) begin
            e.val = model_push(x);
            e.due = cyc + 18;
            sb.push_back(e);
        end
        sample       = 10'(x);
        sample_valid = 1'b1;
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
    endtask

    task automatic send_gap(input int x, input int gap);
        send(x, 1'b1);
        idle(gap - 1);
    endtask

    task automatic set_all(input int c);
        for (int i = 0; i < 16; i++) ctab[i] = c;
    endtask

    task automatic clear_hist();
        for (int i = 0; i < 31; i++) hist[i] = 0;
    endtask

    task automatic run_impulse(input string pfx);
        set_all(0);
        ctab[15] = 16384;
        got.delete();
        send_gap(1000, 20);
        for (int i = 0; i < 20; i++) send_gap(0, 20);
        chk({pfx, "_count"}, got.size(), 21);
        for (int i = 0; i < 21; i++) begin
            if (i == 15) chk({pfx, "_peak"}, got[i], 500);
            else         chk({pfx, "_zero"}, got[i], 0);
        end
    endtask

    initial begin
        reset         = 1'b1;
        sample_valid  = 1'b0;
        sample        = '0;
        clear_overrun = 1'b0;
`ifdef FIR_BYPASS_EN
        bypass        = 1'b0;
`endif
        set_all(0);
        clear_hist();
        idle(3);
        chk("rst_filtered", {22'd0, filtered}, 0);
        chk("rst_valid", {31'd0, filtered_valid}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_overrun", {31'd0, overrun}, 0);
        chk("rst_coef_idx", {28'd0, coef_idx}, 0);
        reset = 1'b0;
        idle(1);

        run_impulse("impulse");

        set_all(1024);
        got.delete();
        for (int i = 0; i < 40; i++) send_gap(1023, 18);
        idle(20);
        chk("dc_first_full", got[30], 991);
        chk("dc_last", got[39], 991);

        set_all(0);
        ctab[15] = 16384;
        got.delete();
        for (int i = 0; i < 20; i++) send_gap(3, 18);
        idle(20);
        chk("round_half_up", got[19], 2);

        set_all(-1024);
        got.delete();
        for (int i = 0; i < 31; i++) send_gap(1023, 18);
        idle(20);
        chk("sat_low", got[30], 0);

        set_all(32767);
        got.delete();
        for (int i = 0; i < 31; i++) send_gap(1023, 18);
        idle(20);
        chk("sat_high", got[30], 1023);

        // Overrun: second strobe at t+5 is dropped.
        set_all(2048);
        chk("ovr_pre", {31'd0, overrun}, 0);
        send(100, 1'b1);
        idle(4);
        sample       = 10'd200;
        sample_valid = 1'b1;
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        chk("ovr_set", {31'd0, overrun}, 1);
        idle(13);
        chk("ovr_sticky", {31'd0, overrun}, 1);
        chk("ovr_idle_busy", {31'd0, busy}, 0);
        send(101, 1'b1);
        idle(2);
        clear_overrun = 1'b1;
        sample        = 10'd55;
        sample_valid  = 1'b1;
        @(posedge clk);
        #1;
        clear_overrun = 1'b0;
        sample_valid  = 1'b0;
        chk("ovr_set_wins", {31'd0, overrun}, 1);
        idle(20);
        clear_overrun = 1'b1;
        @(posedge clk);
        #1;
        clear_overrun = 1'b0;
        chk("ovr_cleared", {31'd0, overrun}, 0);

        // Step sequencing and back-to-back accept in the filtered_valid cycle.
        send(7, 1'b1);
        chk("seq_busy_t1", {31'd0, busy}, 1);
        chk("seq_idx_t1", {28'd0, coef_idx}, 0);
        idle(15);
        chk("seq_idx_t16", {28'd0, coef_idx}, 15);
        idle(1);
        chk("seq_busy_round", {31'd0, busy}, 1);
        idle(1);
        chk("seq_busy_t18", {31'd0, busy}, 0);
        chk("seq_valid_t18", {31'd0, filtered_valid}, 1);
        send(8, 1'b1);
        chk("b2b_busy", {31'd0, busy}, 1);
        idle(20);

        // Reset mid-MAC aborts without issuing an output.
        send(500, 1'b0);
        idle(7);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rstmid_busy", {31'd0, busy}, 0);
        chk("rstmid_filtered", {22'd0, filtered}, 0);
        chk("rstmid_valid", {31'd0, filtered_valid}, 0);
        reset = 1'b0;
        clear_hist();
        idle(25);
        run_impulse("impulse_after_rst");

        // Ramp across several ring wraps with graded symmetric coefficients.
        for (int i = 0; i < 16; i++) ctab[i] = 256 * (i + 1);
        got.delete();
        for (int i = 0; i < 70; i++) send_gap(i, 18);
        idle(20);
        chk("ramp_count", got.size(), 70);

`ifdef FIR_BYPASS_EN
        begin
            exp_t e;
            bypass = 1'b1;
            void'(model_push(777));
            e.val = 777;
            e.due = cyc + 2;
            sb.push_back(e);
            sample       = 10'd777;
            sample_valid = 1'b1;
            @(posedge clk);
            #1;
            sample_valid = 1'b0;
            bypass       = 1'b0;
            chk("byp_busy_t1", {31'd0, busy}, 1);
            idle(1);
            chk("byp_busy_t2", {31'd0, busy}, 0);
            chk("byp_value", {22'd0, filtered}, 777);
            idle(3);
            send_gap(0, 20);
        end
`endif

        for (int i = 0; i < 100; i++) begin
            if (sb.size() == 0) break;
            idle(1);
        end
        chk("sb_drain", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
